// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared opcodes, FSM states and lane helper for the load/store unit
package mem_pkg;

  localparam logic [5:0] INST_I_LB  = 6'h20;
  localparam logic [5:0] INST_I_LH  = 6'h21;
  localparam logic [5:0] INST_I_LW  = 6'h23;
  localparam logic [5:0] INST_I_LBU = 6'h24;
  localparam logic [5:0] INST_I_LHU = 6'h25;
  localparam logic [5:0] INST_I_SB  = 6'h28;
  localparam logic [5:0] INST_I_SH  = 6'h29;
  localparam logic [5:0] INST_I_SW  = 6'h2B;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Big-endian: byte offset 0 lives in lane 3 (bits 31:24).
  function automatic logic [1:0] be_lane(input logic [1:0] off);
    return ~off;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline request, memory port and writeback response bundle
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  modport slave (
    input  req_valid, opcode, addr, wdata, rd, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           resp_valid, resp_rd, resp_data, resp_err, busy
  );

  modport master (
    output req_valid, opcode, addr, wdata, rd, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           resp_valid, resp_rd, resp_data, resp_err, busy
  );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational byte-lane steering and load extension
// SB/SH are only supported when MEM_SUBWORD_STORE_EN is defined.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] sdata_o,
  output logic [31:0] ldata_o,
  output logic        is_mem_o,
  output logic        is_store_o,
  output logic        misalign_o,
  output logic        unsupported_o
);

  logic [1:0]  byte_lane;
  logic [1:0]  half_lane;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // A halfword's lowest lane is the lane of its second byte.
  assign byte_lane = be_lane(off_i);
  assign half_lane = be_lane({off_i[1], 1'b1});
  assign rbyte     = rdata_i[{byte_lane, 3'b000} +: 8];
  assign rhalf     = rdata_i[{half_lane, 3'b000} +: 16];

  always_comb begin
    be_o          = 4'b0000;
    sdata_o       = 32'h0;
    ldata_o       = 32'h0;
    is_mem_o      = 1'b0;
    is_store_o    = 1'b0;
    misalign_o    = 1'b0;
    unsupported_o = 1'b0;
    case (opcode_i)
      INST_I_LB: begin
        is_mem_o = 1'b1;
        be_o     = 4'b1111;
        ldata_o  = {{24{rbyte[7]}}, rbyte};
      end
      INST_I_LBU: begin
        is_mem_o = 1'b1;
        be_o     = 4'b1111;
        ldata_o  = {24'h0, rbyte};
      end
      INST_I_LH: begin
        is_mem_o   = 1'b1;
        be_o       = 4'b1111;
        misalign_o = off_i[0];
        ldata_o    = {{16{rhalf[15]}}, rhalf};
      end
      INST_I_LHU: begin
        is_mem_o   = 1'b1;
        be_o       = 4'b1111;
        misalign_o = off_i[0];
        ldata_o    = {16'h0, rhalf};
      end
      INST_I_LW: begin
        is_mem_o   = 1'b1;
        be_o       = 4'b1111;
        misalign_o = |off_i;
        ldata_o    = rdata_i;
      end
      INST_I_SB: begin
        is_mem_o   = 1'b1;
        is_store_o = 1'b1;
        be_o       = 4'b0001 << byte_lane;
        sdata_o    = {4{wdata_i[7:0]}};
`ifdef MEM_SUBWORD_STORE_EN
        unsupported_o = 1'b0;
`else
        unsupported_o = 1'b1;
`endif
      end
      INST_I_SH: begin
        is_mem_o   = 1'b1;
        is_store_o = 1'b1;
        misalign_o = off_i[0];
        be_o       = 4'b0011 << half_lane;
        sdata_o    = {2{wdata_i[15:0]}};
`ifdef MEM_SUBWORD_STORE_EN
        unsupported_o = 1'b0;
`else
        unsupported_o = 1'b1;
`endif
      end
      INST_I_SW: begin
        is_mem_o   = 1'b1;
        is_store_o = 1'b1;
        misalign_o = |off_i;
        be_o       = 4'b1111;
        sdata_o    = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store unit with timeout
// Sub-word store support follows MEM_SUBWORD_STORE_EN (see mem_lane_align).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  localparam logic [15:0] CNT_LAST = 16'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic [15:0] cnt_q, cnt_d;

  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        idle;
  logic [5:0]  la_opcode;
  logic [1:0]  la_off;
  logic [3:0]  la_be;
  logic [31:0] la_sdata;
  logic [31:0] la_ldata;
  logic        la_is_mem, la_is_store, la_misalign, la_unsupported;

  // In IDLE the aligner decodes the incoming op; afterwards the latched one.
  assign idle      = (state_q == ST_IDLE);
  assign la_opcode = idle ? bus.opcode : opcode_q;
  assign la_off    = idle ? bus.addr[1:0] : off_q;

  mem_lane_align u_align (
    .opcode_i      (la_opcode),
    .off_i         (la_off),
    .wdata_i       (bus.wdata),
    .rdata_i       (bus.mem_rdata),
    .be_o          (la_be),
    .sdata_o       (la_sdata),
    .ldata_o       (la_ldata),
    .is_mem_o      (la_is_mem),
    .is_store_o    (la_is_store),
    .misalign_o    (la_misalign),
    .unsupported_o (la_unsupported)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      opcode_q     <= 6'h0;
      off_q        <= 2'b00;
      rd_q         <= 5'h0;
      cnt_q        <= 16'h0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= 5'h0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    off_d        = off_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    busy_d       = busy_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rd_d    = 5'h0;
    resp_data_d  = 32'h0;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          opcode_d    = bus.opcode;
          off_d       = bus.addr[1:0];
          rd_d        = bus.rd;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (!la_is_mem || la_misalign || la_unsupported) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = la_is_mem;
          end else begin
            state_d     = ST_REQ;
            cnt_d       = 16'h0;
            mem_req_d   = 1'b1;
            mem_we_d    = la_is_store;
            mem_addr_d  = {bus.addr[31:2], 2'b00};
            mem_be_d    = la_be;
            mem_wdata_d = la_is_store ? la_sdata : 32'h0;
          end
        end
      end
      ST_REQ: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (bus.mem_ack || cnt_q == CNT_LAST) begin
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = 32'h0;
          mem_be_d     = 4'h0;
          mem_wdata_d  = 32'h0;
          resp_valid_d = 1'b1;
          if (bus.mem_ack) begin
            resp_rd_d   = la_is_store ? 5'h0 : rd_q;
            resp_data_d = la_is_store ? 32'h0 : la_ldata;
          end else begin
            resp_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = busy_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
// Sub-word store expectations follow MEM_SUBWORD_STORE_EN.
module tb_mem_access_unit;

  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU  = 6'h24;
  localparam logic [5:0] OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SB   = 6'h28;
  localparam logic [5:0] OP_SH   = 6'h29;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_byte(input logic [31:0] w, input int off, input bit sgn);
    logic [7:0] b;
    b = w[31 - 8*off -: 8];
    return sgn ? {{24{b[7]}}, b} : {24'h0, b};
  endfunction

  // Drives one op from an idle unit, plays memory with an ack on cycle ack_cyc
  // (0 = never), and compares the response popped from the scoreboard.
  task automatic run_op(input string tag, input logic [5:0] opc, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] r, input int ack_cyc,
                        input logic [31:0] rdat, input bit exp_mem, input logic exp_we,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [4:0] e_rd, input logic [31:0] e_data, input logic e_err,
                        input int exp_lat, input bit hold);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   seen;
    e.rd = e_rd; e.data = e_data; e.err = e_err;
    @(negedge clk);
    chk({tag, ".ready"}, {31'h0, bus.req_ready}, 32'h1);
    exp_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.opcode    = opc;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.rd        = r;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 30) begin
      if (bus.resp_valid === 1'b1) begin
        seen = 1'b1;
        chk({tag, ".sb_nonempty"}, {31'h0, exp_q.size() != 0}, 32'h1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk({tag, ".resp_rd"}, {27'h0, bus.resp_rd}, {27'h0, got.rd});
          chk({tag, ".resp_data"}, bus.resp_data, got.data);
          chk({tag, ".resp_err"}, {31'h0, bus.resp_err}, {31'h0, got.err});
        end
        chk({tag, ".latency"}, cyc, exp_lat);
        chk({tag, ".mem_req_at_resp"}, {31'h0, bus.mem_req}, 32'h0);
      end else begin
        chk({tag, ".mem_req"}, {31'h0, bus.mem_req}, {31'h0, exp_mem});
        chk({tag, ".busy_ready"}, {30'h0, bus.busy, bus.req_ready}, 32'h2);
        if (exp_mem && cyc == 1) begin
          chk({tag, ".mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
          chk({tag, ".mem_we"}, {31'h0, bus.mem_we}, {31'h0, exp_we});
          chk({tag, ".mem_be"}, {28'h0, bus.mem_be}, {28'h0, exp_be});
          chk({tag, ".mem_wdata"}, bus.mem_wdata, exp_wd);
        end
        bus.mem_ack   = (cyc == ack_cyc);
        bus.mem_rdata = (cyc == ack_cyc) ? rdat : $urandom();
        @(negedge clk);
        cyc++;
      end
    end
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'b0;
    chk({tag, ".resp_seen"}, {31'h0, seen}, 32'h1);
    @(negedge clk);
    chk({tag, ".resp_cleared"}, {bus.resp_data[30:0], bus.resp_valid}, 32'h0);
    chk({tag, ".ready_after"}, {31'h0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] pat;
    bus.req_valid = 1'b0;
    bus.opcode    = 6'h0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.rd        = 5'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset.ready_busy", {30'h0, bus.req_ready, bus.busy}, 32'h2);
    chk("reset.mem_ctl", {26'h0, bus.mem_req, bus.mem_we, bus.mem_be}, 32'h0);
    chk("reset.mem_addr", bus.mem_addr, 32'h0);
    chk("reset.mem_wdata", bus.mem_wdata, 32'h0);
    chk("reset.resp_ctl", {25'h0, bus.resp_valid, bus.resp_err, bus.resp_rd}, 32'h0);
    chk("reset.resp_data", bus.resp_data, 32'h0);
    rst = 1'b1;

    // Ack while idle must be ignored.
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("idle_ack.ignored", {30'h0, bus.resp_valid, bus.mem_req}, 32'h0);

    run_op("lw", OP_LW, 32'h100, 32'h0, 5'd5, 1, 32'hDEADBEEF, 1, 1'b0, 4'hF, 32'h0,
           5'd5, 32'hDEADBEEF, 1'b0, 2, 0);
    run_op("lb", OP_LB, 32'h103, 32'h0, 5'd6, 2, 32'h123456F0, 1, 1'b0, 4'hF, 32'h0,
           5'd6, 32'hFFFFFFF0, 1'b0, 3, 0);
    run_op("lbu", OP_LBU, 32'h103, 32'h0, 5'd7, 1, 32'h123456F0, 1, 1'b0, 4'hF, 32'h0,
           5'd7, 32'h000000F0, 1'b0, 2, 0);
    run_op("lhu", OP_LHU, 32'h102, 32'h0, 5'd8, 1, 32'h123456F0, 1, 1'b0, 4'hF, 32'h0,
           5'd8, 32'h000056F0, 1'b0, 2, 0);
    run_op("lh_hi", OP_LH, 32'h100, 32'h0, 5'd9, 1, 32'h80010000, 1, 1'b0, 4'hF, 32'h0,
           5'd9, 32'hFFFF8001, 1'b0, 2, 0);

    pat = 32'h807F01FE;
    for (int off = 0; off < 4; off++) begin
      run_op("lb_lane", OP_LB, 32'h140 + 32'(off), 32'h0, 5'd10, 1, pat, 1, 1'b0, 4'hF, 32'h0,
             5'd10, model_byte(pat, off, 1'b1), 1'b0, 2, 0);
      run_op("lbu_lane", OP_LBU, 32'h140 + 32'(off), 32'h0, 5'd11, 1, pat, 1, 1'b0, 4'hF, 32'h0,
             5'd11, model_byte(pat, off, 1'b0), 1'b0, 2, 0);
    end

`ifdef MEM_SUBWORD_STORE_EN
    run_op("sb", OP_SB, 32'h201, 32'h000000AB, 5'd7, 1, 32'h0, 1, 1'b1, 4'b0100, 32'hABABABAB,
           5'd0, 32'h0, 1'b0, 2, 0);
    run_op("sh", OP_SH, 32'h202, 32'h1234CDEF, 5'd7, 1, 32'h0, 1, 1'b1, 4'b0011, 32'hCDEFCDEF,
           5'd0, 32'h0, 1'b0, 2, 0);
`else
    run_op("sb", OP_SB, 32'h201, 32'h000000AB, 5'd7, 0, 32'h0, 0, 1'b0, 4'h0, 32'h0,
           5'd0, 32'h0, 1'b1, 1, 0);
    run_op("sh", OP_SH, 32'h202, 32'h1234CDEF, 5'd7, 0, 32'h0, 0, 1'b0, 4'h0, 32'h0,
           5'd0, 32'h0, 1'b1, 1, 0);
`endif
    run_op("sw", OP_SW, 32'h300, 32'hCAFEF00D, 5'd12, 3, 32'h0, 1, 1'b1, 4'hF, 32'hCAFEF00D,
           5'd0, 32'h0, 1'b0, 4, 0);
    run_op("lh_misalign", OP_LH, 32'h101, 32'h0, 5'd13, 0, 32'h0, 0, 1'b0, 4'h0, 32'h0,
           5'd0, 32'h0, 1'b1, 1, 0);
    run_op("lw_misalign", OP_LW, 32'h102, 32'h0, 5'd13, 0, 32'h0, 0, 1'b0, 4'h0, 32'h0,
           5'd0, 32'h0, 1'b1, 1, 0);
    run_op("non_mem", OP_ADDI, 32'h104, 32'h0, 5'd9, 0, 32'h0, 0, 1'b0, 4'h0, 32'h0,
           5'd0, 32'h0, 1'b0, 1, 0);
    run_op("timeout", OP_LW, 32'h400, 32'h0, 5'd14, 0, 32'h0, 1, 1'b0, 4'hF, 32'h0,
           5'd0, 32'h0, 1'b1, 5, 0);
    run_op("ack_at_limit", OP_LW, 32'h404, 32'h0, 5'd15, 4, 32'h0BADF00D, 1, 1'b0, 4'hF, 32'h0,
           5'd15, 32'h0BADF00D, 1'b0, 5, 0);

    // Reset in the middle of a request: no response, mem_req drops at once.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.opcode    = OP_LW;
    bus.addr      = 32'h500;
    bus.rd        = 5'd3;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_mid.mem_req_before", {31'h0, bus.mem_req}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid.mem_req_after", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_mid.ready_busy", {29'h0, bus.resp_valid, bus.req_ready, bus.busy}, 32'h2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.no_resp", {31'h0, bus.resp_valid}, 32'h0);

    run_op("held_lw", OP_LW, 32'h600, 32'h0, 5'd4, 2, 32'h11223344, 1, 1'b0, 4'hF, 32'h0,
           5'd4, 32'h11223344, 1'b0, 3, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_lw.single_accept", {30'h0, bus.mem_req, bus.resp_valid}, 32'h0);
    end
    chk("scoreboard.drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
